mtp_seq_ctrl: RTL and testbench



---
 rtl/mtp_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mtp_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtp_seq_ctrl.sv
// Multicycle instruction sequencer: fetch over a req/ack port, then step each word
// through decode/execute/memory/write-back with run control and a bus watchdog.
module mtp_seq_ctrl #(
    parameter int unsigned    AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter logic [AW-1:0]  PC_STEP  = AW'(4),
    parameter int unsigned    TIMEOUT  = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_stop,
    output logic          o_imem_req,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_ack,
    input  logic [31:0]   i_imem_rdata,
    output logic [31:0]   o_ir,
    output logic          o_alu_en,
    output logic          o_dmem_req,
    output logic          o_dmem_we,
    input  logic          i_dmem_ack,
    output logic          o_reg_we,
    output logic          o_busy,
    output logic          o_halted,
    output logic          o_err,
    output logic [31:0]   o_retired,
    output logic [2:0]    o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'b1111;
    localparam logic [3:0] OP_LOAD   = 4'b0100;
    localparam logic [3:0] OP_STORE  = 4'b0110;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_ir;
    logic [31:0]   r_retired;
    logic          r_err;
    logic          r_stop_pend;
    logic [7:0]    r_wait;

    logic [3:0]    w_op;
    logic          w_is_halt;
    logic          w_is_store;
    logic          w_is_mem;
    logic          w_stop_now;
    logic          w_wait_expired;
    logic          w_retire;
    logic          w_timeout;
    logic          w_waiting;

    assign w_op           = r_ir[18:15];
    assign w_is_halt      = (r_ir == 32'hFFFF_FFFF);
    assign w_is_store     = (w_op == OP_STORE);
    assign w_is_mem       = (w_op == OP_LOAD) || w_is_store;
    assign w_stop_now     = r_stop_pend || i_stop;
    assign w_wait_expired = (r_wait == WAIT_LAST);
    assign w_waiting      = (r_state == S_FETCH) || (r_state == S_MEM);

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_state_nxt = S_DECODE;
                end else if (w_wait_expired) begin
                    w_state_nxt = S_HALT;
                    w_timeout   = 1'b1;
                end
            end
            S_DECODE: begin
                // The all-ones HALT word also carries the NOP opcode, so test it first.
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else if (w_op == OP_NOP) begin
                    w_retire    = 1'b1;
                    w_state_nxt = w_stop_now ? S_IDLE : S_FETCH;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = w_is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (i_dmem_ack) begin
                    if (w_is_store) begin
                        w_retire    = 1'b1;
                        w_state_nxt = w_stop_now ? S_IDLE : S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_wait_expired) begin
                    w_state_nxt = S_HALT;
                    w_timeout   = 1'b1;
                end
            end
            S_WB: begin
                w_retire    = 1'b1;
                w_state_nxt = w_stop_now ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (i_stop)       w_state_nxt = S_IDLE;
                else if (i_start) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_retired   <= '0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH && i_imem_ack) begin
                r_ir <= i_imem_rdata;
                r_pc <= r_pc + PC_STEP;
            end
            if (w_retire) r_retired <= r_retired + 32'd1;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (r_state == S_HALT && i_start && !i_stop) begin
                r_err <= 1'b0;
            end
            // A pending stop never outlives a return to IDLE or HALT.
            if (w_state_nxt == S_IDLE || w_state_nxt == S_HALT) begin
                r_stop_pend <= 1'b0;
            end else if (i_stop && o_busy) begin
                r_stop_pend <= 1'b1;
            end
            if (w_waiting && w_state_nxt == r_state) r_wait <= r_wait + 8'd1;
            else                                     r_wait <= '0;
        end
    end

    assign o_imem_req  = (r_state == S_FETCH);
    assign o_imem_addr = r_pc;
    assign o_ir        = r_ir;
    assign o_alu_en    = (r_state == S_EXEC);
    assign o_dmem_req  = (r_state == S_MEM);
    assign o_dmem_we   = (r_state == S_MEM) && w_is_store;
    assign o_reg_we    = (r_state == S_WB);
    assign o_busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                         (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);
    assign o_halted    = (r_state == S_HALT);
    assign o_err       = r_err;
    assign o_retired   = r_retired;
    assign o_state     = r_state;

endmodule

// File: tb/tb_mtp_seq_ctrl.sv
// Bench for mtp_seq_ctrl: table of instruction records run through a small
// memory responder, with expected results queued and compared at each boundary.
module tb_mtp_seq_ctrl;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_ack;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   ir;
    logic          alu_en;
    logic          dmem_req;
    logic          dmem_we;
    logic          reg_we;
    logic          busy;
    logic          halted;
    logic          err;
    logic [31:0]   retired;
    logic [2:0]    state;

    always #5 clk = ~clk;

    mtp_seq_ctrl #(
        .AW(AW), .RESET_PC(32'h0), .PC_STEP(32'd4), .TIMEOUT(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
        .i_imem_rdata(imem_rdata), .o_ir(ir), .o_alu_en(alu_en),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
        .o_reg_we(reg_we), .o_busy(busy), .o_halted(halted), .o_err(err),
        .o_retired(retired), .o_state(state)
    );

    typedef struct {
        logic [31:0] word;
        int          iwait;
        int          dwait;
        int          stop_at;
        logic [23:0] trace;
        int          ret_inc;
        int          regwe;
        int          aluen;
        int          dmemwe;
        logic [2:0]  end_st;
        bit          fetched;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[10];
    vec_t        sbq[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic [31:0] exp_ret;

    function automatic vec_t mk(logic [31:0] w, int iw, int dw, int sa, logic [23:0] tr,
                                int ri, int rw, int al, int dm, logic [2:0] es, bit f);
        vec_t v;
        v.word = w; v.iwait = iw; v.dwait = dw; v.stop_at = sa; v.trace = tr;
        v.ret_inc = ri; v.regwe = rw; v.aluen = al; v.dmemwe = dm; v.end_st = es; v.fetched = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Serve one instruction from its first FETCH cycle up to the next boundary.
    task automatic run_vec(input int idx, input vec_t v);
        int          cyc, fw, dw, n_regwe, n_aluen, n_dmemwe;
        logic [23:0] tr;
        bit          left;
        vec_t        e;
        cyc = 0; fw = 0; dw = 0; n_regwe = 0; n_aluen = 0; n_dmemwe = 0;
        tr = '0; left = 1'b0;
        sbq.push_back(v);
        chk($sformatf("v%0d_start_addr", idx), imem_addr, exp_pc);
        while (cyc < 100) begin
            imem_ack = 1'b0; dmem_ack = 1'b0; stop = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (state == 3'd1) begin
                if (fw == v.iwait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = v.word;
                end
                fw++;
            end
            if (state == 3'd4) begin
                if (dw == v.dwait) dmem_ack = 1'b1;
                dw++;
            end
            if (v.stop_at >= 0 && int'(state) == v.stop_at) stop = 1'b1;
            tr = {tr[20:0], state};
            n_regwe  += int'(reg_we);
            n_aluen  += int'(alu_en);
            n_dmemwe += int'(dmem_req && dmem_we);
            step();
            cyc++;
            if (state != 3'd1) left = 1'b1;
            if ((left && state == 3'd1) || state == 3'd0 || state == 3'd6) break;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; stop = 1'b0;
        chk($sformatf("v%0d_cycle_bound", idx), 32'(cyc < 100), 32'd1);
        e = sbq.pop_front();
        if (e.fetched) begin
            exp_pc = exp_pc + 32'd4;
            exp_ir = e.word;
        end
        exp_ret = exp_ret + 32'(e.ret_inc);
        chk($sformatf("v%0d_state_trace", idx), 32'(tr), 32'(e.trace));
        chk($sformatf("v%0d_reg_we_cycles", idx), 32'(n_regwe), 32'(e.regwe));
        chk($sformatf("v%0d_alu_en_cycles", idx), 32'(n_aluen), 32'(e.aluen));
        chk($sformatf("v%0d_dmem_we_cycles", idx), 32'(n_dmemwe), 32'(e.dmemwe));
        chk($sformatf("v%0d_end_state", idx), 32'(state), 32'(e.end_st));
        chk($sformatf("v%0d_retired", idx), retired, exp_ret);
        chk($sformatf("v%0d_ir", idx), ir, exp_ir);
        chk($sformatf("v%0d_pc", idx), imem_addr, exp_pc);
    endtask

    initial begin
        // Traces are octal digit strings of the state seen in each cycle.
        vecs[0] = mk(32'h0000_0000, 0, 0, -1, 24'o1235,     1, 1, 1, 0, 3'd1, 1'b1);
        vecs[1] = mk(32'h0002_0000, 0, 3, -1, 24'o12344445, 1, 1, 1, 0, 3'd1, 1'b1);
        vecs[2] = mk(32'h0003_0000, 0, 0, -1, 24'o1234,     1, 0, 1, 1, 3'd1, 1'b1);
        vecs[3] = mk(32'h1234_5678, 2, 0, -1, 24'o111235,   1, 1, 1, 0, 3'd1, 1'b1);
        vecs[4] = mk(32'h0007_8000, 0, 0, -1, 24'o12,       1, 0, 0, 0, 3'd1, 1'b1);
        vecs[5] = mk(32'hFFFF_FFFF, 0, 0, -1, 24'o12,       0, 0, 0, 0, 3'd6, 1'b1);
        vecs[6] = mk(32'h0000_0001, 0, 0,  3, 24'o1235,     1, 1, 1, 0, 3'd0, 1'b1);
        vecs[7] = mk(32'hAAAA_AAAA, 99, 0, -1, 24'o11111,   0, 0, 0, 0, 3'd6, 1'b0);
        vecs[8] = mk(32'h0002_0000, 0, 99, -1, 24'o12344444, 0, 0, 1, 0, 3'd6, 1'b1);
        vecs[9] = mk(32'h0000_0002, 0, 0, -1, 24'o1235,     1, 1, 1, 0, 3'd1, 1'b1);

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        exp_pc = 32'h0; exp_ir = 32'h0; exp_ret = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'({imem_req, dmem_req, dmem_we, alu_en, reg_we}), 32'd0);
        chk("rst_busy_halted_err", 32'({busy, halted, err}), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_pc", imem_addr, 32'd0);
        chk("rst_ir", ir, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_no_start", 32'(state), 32'd0);
        pulse_start();
        chk("start_to_fetch", 32'(state), 32'd1);
        chk("fetch_req", 32'(imem_req), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
        chk("halt_halted", 32'({halted, busy}), 32'b10);
        pulse_start();
        chk("halt_resume_state", 32'(state), 32'd1);
        chk("halt_resume_addr", imem_addr, 32'd24);

        run_vec(6, vecs[6]);
        chk("stop_busy", 32'(busy), 32'd0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", 32'(state), 32'd0);
        pulse_start();
        chk("stop_resume_addr", imem_addr, 32'd28);

        run_vec(7, vecs[7]);
        chk("itimeout_err", 32'({err, halted}), 32'b11);
        pulse_start();
        chk("itimeout_clear_err", 32'(err), 32'd0);
        chk("itimeout_refetch", 32'({imem_req, imem_addr}), {1'b1, 32'd28});

        run_vec(8, vecs[8]);
        chk("dtimeout_err", 32'(err), 32'd1);
        pulse_start();
        chk("dtimeout_resume", 32'({err, imem_req}), 32'b01);

        run_vec(9, vecs[9]);
        chk("pre_reset_retired", retired, 32'd7);

        imem_ack = 1'b1; imem_rdata = 32'h0002_0000;
        step();
        imem_ack = 1'b0;
        step();
        step();
        chk("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_retired", retired, 32'd0);
        chk("async_rst_pc", imem_addr, 32'd0);
        chk("async_rst_flags", 32'({busy, halted, err, imem_req, reg_we, alu_en}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        chk("post_rst_fetch", 32'({imem_req, imem_addr}), {1'b1, 32'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
